// File: rtl/ysyx_23060180_dmem.sv
// Single-port data/instruction RAM behind the core memory port, with 1-cycle registered reads,
// a one-entry store buffer with read forwarding, and sticky fault logging. Optional: YSYX_23060180_DMEM_MISALIGN_EN.
module ysyx_23060180_dmem #(
  parameter logic [31:0] ADDR_BASE = 32'h80000000,
  parameter int          AW        = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] mem_raddr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wbit_en,
  output logic [31:0] mem_rdata,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [7:0]  fault_cnt
);

  localparam logic [32:0] BASE33  = {1'b0, ADDR_BASE};
  localparam logic [32:0] LIMIT33 = BASE33 + (33'd4 << AW);

  logic [31:0] ram [2**AW];

  logic          wb_vld_q, wb_vld_d;
  logic [AW-1:0] wb_idx_q, wb_idx_d;
  logic [3:0]    wb_strb_q, wb_strb_d;
  logic [31:0]   wb_dat_q, wb_dat_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          fault_q, fault_d;
  logic [31:0]   fault_addr_q, fault_addr_d;
  logic [7:0]    fault_cnt_q, fault_cnt_d;

  logic [32:0]   addr33;
  logic          in_range;
  logic [31:0]   rel;
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic [3:0]    mask;
  logic          size_ok;
  logic [7:0]    strb_full;
  logic [3:0]    strb;
  logic [31:0]   wdat;
  logic          rd_mis, wr_mis;
  logic          rd_fault, wr_fault, any_fault;
  logic [31:0]   arr_word, rd_word;
  logic          unused_bits;

  always_comb begin
    addr33    = {1'b0, mem_raddr};
    in_range  = (addr33 >= BASE33) && (addr33 < LIMIT33);
    rel       = mem_raddr - ADDR_BASE;
    idx       = rel[AW+1:2];
    off       = mem_raddr[1:0];
    mask      = 4'b0000;
    size_ok   = 1'b0;
    case (mem_wbit_en)
      4'd1:    begin mask = 4'b0001; size_ok = 1'b1; end
      4'd2:    begin mask = 4'b0011; size_ok = 1'b1; end
      4'd4:    begin mask = 4'b1111; size_ok = 1'b1; end
      default: begin mask = 4'b0000; size_ok = 1'b0; end
    endcase
    // Lanes shifted past lane 3 fall off here, giving partial stores.
    strb_full = {4'b0000, mask} << off;
    strb      = strb_full[3:0];
    wdat      = mem_wdata << {off, 3'b000};
  end

  assign unused_bits = ^{rel[31:AW+2], rel[1:0], strb_full[7:4]};

`ifdef YSYX_23060180_DMEM_MISALIGN_EN
  logic [3:0] rd_size;
  always_comb begin
    // A combined read/store uses the store size; a bare read is a full word.
    rd_size = (mem_wr && size_ok) ? mem_wbit_en : 4'd4;
    rd_mis  = ({2'b00, off} + rd_size) > 4'd4;
    wr_mis  = size_ok && (({2'b00, off} + mem_wbit_en) > 4'd4);
  end
`else
  always_comb begin
    rd_mis = 1'b0;
    wr_mis = 1'b0;
  end
`endif

  always_comb begin
    rd_fault  = mem_rd && (!in_range || rd_mis);
    wr_fault  = mem_wr && (!in_range || !size_ok || wr_mis);
    any_fault = rd_fault || wr_fault;

    arr_word = ram[idx];
    rd_word  = arr_word;
    for (int i = 0; i < 4; i++) begin
      if (wb_vld_q && (wb_idx_q == idx) && wb_strb_q[i]) begin
        rd_word[8*i +: 8] = wb_dat_q[8*i +: 8];
      end
    end

    rdata_d = rdata_q;
    if (mem_rd) begin
      rdata_d = rd_fault ? 32'h0 : (rd_word >> {off, 3'b000});
    end

    // The buffer drains every cycle; a legal store refills it on the same edge.
    wb_vld_d  = mem_wr && !wr_fault;
    wb_idx_d  = wb_idx_q;
    wb_strb_d = wb_strb_q;
    wb_dat_d  = wb_dat_q;
    if (mem_wr && !wr_fault) begin
      wb_idx_d  = idx;
      wb_strb_d = strb;
      wb_dat_d  = wdat;
    end

    fault_d      = fault_q || any_fault;
    fault_addr_d = (any_fault && !fault_q) ? mem_raddr : fault_addr_q;
    fault_cnt_d  = (any_fault && (fault_cnt_q != 8'hFF)) ? fault_cnt_q + 8'd1 : fault_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_vld_q     <= 1'b0;
      wb_idx_q     <= '0;
      wb_strb_q    <= 4'b0000;
      wb_dat_q     <= 32'h0;
      rdata_q      <= 32'h0;
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0;
      fault_cnt_q  <= 8'h0;
    end else begin
      wb_vld_q     <= wb_vld_d;
      wb_idx_q     <= wb_idx_d;
      wb_strb_q    <= wb_strb_d;
      wb_dat_q     <= wb_dat_d;
      rdata_q      <= rdata_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      fault_cnt_q  <= fault_cnt_d;
    end
  end

  // Array has no reset; a store still pending when reset hits is dropped.
  always_ff @(posedge clk) begin
    if (!rst && wb_vld_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wb_strb_q[i]) begin
          ram[wb_idx_q][8*i +: 8] <= wb_dat_q[8*i +: 8];
        end
      end
    end
  end

  assign mem_rdata  = rdata_q;
  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;
  assign fault_cnt  = fault_cnt_q;

endmodule

// File: doc/ysyx_23060180_dmem.md
# ysyx_23060180_dmem

On-chip data/instruction RAM that sits directly downstream of the CPU core's single memory port. It consumes the core's `mem_rd`/`mem_wr` requests and returns read data with a fixed one-cycle latency, matching the core's `mem_rd`-delayed-by-one sampling. Internally it decodes the address window, converts the core's byte-count write size into lane strobes, buffers stores by one cycle with read forwarding, right-aligns read data and records access faults.

## Interface
- `ADDR_BASE`, default 32'h80000000: first byte address of the RAM window.
- `AW`, default 12: word-index width; the array holds 2^AW 32-bit words.
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `mem_rd`, input, 1: read request this cycle.
- `mem_wr`, input, 1: write request this cycle.
- `mem_raddr`, input, 32: byte address for both reads and writes.
- `mem_wdata`, input, 32: store data, right-aligned (byte 0 in [7:0]).
- `mem_wbit_en`, input, 4: store size in bytes: 1, 2 or 4.
- `mem_rdata`, output, 32: registered read data, right-aligned.
- `fault`, output, 1: sticky flag, set on the first faulting access.
- `fault_addr`, output, 32: address of the first faulting access.
- `fault_cnt`, output, 8: count of faulting accesses, saturating at 255.

## Operation
- **Decode.**
  - `in_range` is true when `ADDR_BASE <= addr < ADDR_BASE + 4*2^AW`. Compute the comparison with 33-bit arithmetic, so there is no wrap at 2^32.
  - `idx = (addr - ADDR_BASE)[AW+1:2]` and `off = addr[1:0]`.
- **Store size to mask.**
  - `mem_wbit_en` 1 → mask 4'b0001; 2 → 4'b0011; 4 → 4'b1111.
  - Any other value is a size fault; no write is performed.
  - Lane strobe is `mask << off`. Data is `mem_wdata << 8*off`. Both are truncated to 4 lanes.
- **Write buffer (WB): one entry, holding {valid, idx, strobe, data}.**
  - A legal `mem_wr` loads WB.
  - A valid WB entry commits its strobed bytes to the array on the following edge.
  - Back-to-back stores are allowed: the array commit and the new WB load happen on the same edge.
- **Read.**
  - When `mem_rd` is high, the source word is the array word at `idx`.
  - If WB is valid with the same `idx`, its strobed bytes are forwarded over the array bytes.
  - `mem_rdata` is registered as `word >> 8*off`, zero-filled. The core applies its own sign/zero extension.
- **Read and write in the same cycle.** If `mem_rd` and `mem_wr` are both high, the read returns data from before this cycle's store (WB contents are still forwarded). The store proceeds normally.
- **No request.** With neither `mem_rd` nor `mem_wr` asserted, `mem_rdata` holds its value and WB drains.
- **Faults.**
  - A fault is any of: an out-of-range `mem_rd` or `mem_wr`, a store size fault, or a misalignment fault (see Configuration).
  - A faulting store does not load WB.
  - A faulting read registers `mem_rdata = 0`.
  - `fault_cnt` increments by 1 per faulting cycle. A cycle with both `mem_rd` and `mem_wr` faulting counts once.
- **Array contents.** The array is not cleared by reset.

## Timing
- **Read latency.** `mem_rd` in cycle t gives `mem_rdata` valid in cycle t+1 and held until the next read or reset.
- **Store visibility.**
  - A store in cycle t is visible to a read in cycle t+1 via forwarding.
  - It is in the array after the edge ending cycle t+1.
- **Fault outputs.**
  - `fault` and `fault_cnt` update on the edge ending the faulting cycle.
  - `fault_addr` is captured only when `fault` was 0.
- **Reset values** (`rst` high at an edge):
  - `mem_rdata` = 0, `fault` = 0, `fault_addr` = 0, `fault_cnt` = 0.
  - WB.valid = 0: a pending store is discarded, never committed.
  - Requests presented in a reset cycle are ignored.

## Configuration
- Macro: `YSYX_23060180_DMEM_MISALIGN_EN`.
- **Defined.**
  - Any access with `off + size > 4` is a misalignment fault. Read size is taken as 4 when only `mem_rd` is set, so only `off == 0` reads are legal.
  - A misaligned store is suppressed and a misaligned read returns 0.
- **Undefined.**
  - No misalignment check.
  - Strobe lanes shifted past lane 3 are dropped, so stores are partial.
  - Reads return the zero-filled shifted word.

## Test plan
- Store 0xDEADBEEF to 0x80000010 with `wbit_en` 4, then `mem_rd` at 0x80000010 next cycle → `mem_rdata` 0xDEADBEEF one cycle later (forwarded). Repeat 3 cycles later → same value from the array.
- After the test above, store 0x000000AA to 0x80000013 with `wbit_en` 1:
  - read 0x80000010 → 0xAAADBEEF;
  - read 0x80000012 with the macro undefined → 0x0000AAAD.
- `mem_rd` at 0x7FFFFFFC → `mem_rdata` 0, `fault` 1, `fault_addr` 0x7FFFFFFC, `fault_cnt` 1.
- A second fault at 0x90000000 → `fault_addr` unchanged, `fault_cnt` 2. After 300 faults → `fault_cnt` 255.
- Store 0x1234 to 0x80000013 with `wbit_en` 2:
  - with the macro defined → fault, word unchanged;
  - without the macro → only byte 3 = 0x34.
- Store with `wbit_en` 3 → fault and no write.
- Store to 0x80000020, then `rst` high the next cycle → read of 0x80000020 returns its old value, and all outputs are 0 during reset.
